// File: rtl/fxp_accumulator.sv
// Frame accumulator for signed fixed-point product terms with sticky overflow tracking.
// Define FXP_ACC_SAT_EN to clamp the accumulator on overflow; by default it wraps.
module fxp_accumulator #(
    parameter int WII  = 12,
    parameter int WFI  = 7,
    parameter int WIA  = 16,
    parameter int NACC = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WII+WFI-1:0]     in_data,
    input  logic                   in_ovf,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIA+WFI-1:0]     out_data,
    output logic                   out_ovf,
    output logic [7:0]             out_count
);
    localparam int WA = WIA + WFI;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic signed [WA-1:0]  acc_q, acc_d;
    logic [7:0]            count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  out_valid_q, out_valid_d;
    logic [WA-1:0]         out_data_q, out_data_d;
    logic                  out_ovf_q, out_ovf_d;
    logic [7:0]            out_count_q, out_count_d;

    logic                  accept_s;
    logic signed [WA-1:0]  term_s, base_s, sum_s, acc_next_s;
    logic [7:0]            count_base_s;
    logic                  ovf_base_s, add_ovf_s;

    assign in_ready  = (state_q != DONE);
    assign accept_s  = in_valid && in_ready;
    assign term_s    = WA'($signed(in_data));
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_count = out_count_q;

    // Datapath: an IDLE accept adds onto zero, so loading and accumulating share one adder.
    always_comb begin
        base_s       = (state_q == IDLE) ? {WA{1'b0}} : acc_q;
        count_base_s = (state_q == IDLE) ? 8'd0 : count_q;
        ovf_base_s   = (state_q == IDLE) ? 1'b0 : ovf_q;
        sum_s        = base_s + term_s;
        add_ovf_s    = (base_s[WA-1] == term_s[WA-1]) && (sum_s[WA-1] != base_s[WA-1]);
        acc_next_s   = sum_s;
`ifdef FXP_ACC_SAT_EN
        if (add_ovf_s) begin
            acc_next_s = base_s[WA-1] ? {1'b1, {(WA-1){1'b0}}} : {1'b0, {(WA-1){1'b1}}};
        end else begin
            acc_next_s = sum_s;
        end
`endif
    end

    // Next-state and output-register logic.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_count_d = out_count_q;
        case (state_q)
            IDLE, ACC: begin
                if (accept_s) begin
                    acc_d   = acc_next_s;
                    count_d = count_base_s + 8'd1;
                    ovf_d   = ovf_base_s | in_ovf | add_ovf_s;
                    if (in_last || (count_d == 8'(NACC))) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        out_data_d  = acc_next_s;
                        out_count_d = count_d;
                        out_ovf_d   = ovf_d;
                    end else begin
                        state_d = ACC;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= {WA{1'b0}};
            count_q     <= 8'd0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {WA{1'b0}};
            out_ovf_q   <= 1'b0;
            out_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_count_q <= out_count_d;
        end
    end
endmodule

// File: tb/tb_fxp_accumulator.sv
// Directed bench for fxp_accumulator: vector table of frames plus hand sequences for
// NACC termination, back-pressure, mid-frame reset and overflow in a narrow build.
module tb_fxp_accumulator;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_ovf, in_last;
    logic [18:0] in_data;
    logic        out_valid, out_ready, out_ovf;
    logic [22:0] out_data;
    logic [7:0]  out_count;

    logic        b_in_valid, b_in_ready, b_in_ovf, b_in_last;
    logic [18:0] b_in_data;
    logic        b_out_valid, b_out_ready, b_out_ovf;
    logic [18:0] b_out_data;
    logic [7:0]  b_out_count;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fxp_accumulator dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_ovf(in_ovf), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .out_count(out_count)
    );

    fxp_accumulator #(.WIA(12), .NACC(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_ovf(b_in_ovf), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_ovf(b_out_ovf), .out_count(b_out_count)
    );

    typedef struct {
        int               n;
        logic [3:0][18:0] t;
        logic [3:0]       ovf_m;
        int               gap;
        int               exp_data;
        int               exp_cnt;
        int               exp_ovf;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic send(input logic [18:0] d, input logic o, input logic l);
        @(negedge clk);
        chk("in_ready", int'(in_ready), 1);
        in_valid = 1'b1; in_data = d; in_ovf = o; in_last = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_ovf = 1'b0; in_last = 1'b0;
    endtask

    task automatic take();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_drop", int'(out_valid), 0);
        chk("in_ready_idle", int'(in_ready), 1);
    endtask

    task automatic chk_result(input string name, input int d, input int c, input int o);
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_data"}, int'($signed(out_data)), d);
        chk({name, "_count"}, int'(out_count), c);
        chk({name, "_ovf"}, int'(out_ovf), o);
    endtask

    initial begin
        int exp_b;
        rst = 1'b1;
        in_valid = 1'b0; in_data = 19'd0; in_ovf = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = 19'd0; b_in_ovf = 1'b0; b_in_last = 1'b0; b_out_ready = 1'b0;

        vecs[0].n = 3; vecs[0].gap = 0; vecs[0].ovf_m = 4'b0000;
        vecs[0].t[0] = 19'(128); vecs[0].t[1] = 19'(-384); vecs[0].t[2] = 19'(64); vecs[0].t[3] = 19'(0);
        vecs[0].exp_data = -192; vecs[0].exp_cnt = 3; vecs[0].exp_ovf = 0;
        vecs[1].n = 4; vecs[1].gap = 2; vecs[1].ovf_m = 4'b0010;
        vecs[1].t[0] = 19'(100); vecs[1].t[1] = 19'(200); vecs[1].t[2] = 19'(-50); vecs[1].t[3] = 19'(10);
        vecs[1].exp_data = 260; vecs[1].exp_cnt = 4; vecs[1].exp_ovf = 1;
        vecs[2].n = 1; vecs[2].gap = 0; vecs[2].ovf_m = 4'b0000;
        vecs[2].t[0] = 19'(-1); vecs[2].t[1] = 19'(0); vecs[2].t[2] = 19'(0); vecs[2].t[3] = 19'(0);
        vecs[2].exp_data = -1; vecs[2].exp_cnt = 1; vecs[2].exp_ovf = 0;
        vecs[3].n = 2; vecs[3].gap = 0; vecs[3].ovf_m = 4'b0000;
        vecs[3].t[0] = 19'(-262144); vecs[3].t[1] = 19'(-262144); vecs[3].t[2] = 19'(0); vecs[3].t[3] = 19'(0);
        vecs[3].exp_data = -524288; vecs[3].exp_cnt = 2; vecs[3].exp_ovf = 0;

        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_count", int'(out_count), 0);
        chk("rst_out_ovf", int'(out_ovf), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        // Table of frames terminated by in_last; gap cycles carry in_last with in_valid low.
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < vecs[v].n; k++) begin
                send(vecs[v].t[k], vecs[v].ovf_m[k], (k == vecs[v].n - 1));
                if (k < vecs[v].n - 1) begin
                    repeat (vecs[v].gap) begin
                        @(negedge clk);
                        in_last = 1'b1;
                    end
                    if (vecs[v].gap > 0) begin
                        @(negedge clk);
                        chk("gap_no_done", int'(out_valid), 0);
                        in_last = 1'b0;
                    end
                end
            end
            chk_result($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_cnt, vecs[v].exp_ovf);
            take();
        end

        // Eight terms of 1.5 with no in_last: frame closes on the term count.
        for (int i = 0; i < 8; i++) begin
            send(19'(192), 1'b0, 1'b0);
            if (i < 7) chk("nacc_early", int'(out_valid), 0);
        end
        chk_result("nacc8", 1536, 8, 0);

        // Back-pressure: result held, inputs refused while out_ready stays low.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 19'(5);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_data", int'($signed(out_data)), 1536);
            chk("bp_count", int'(out_count), 8);
        end
        take();

        // Reset mid-frame discards the partial sum and clears the held result.
        send(19'(10), 1'b0, 1'b0);
        send(19'(20), 1'b1, 1'b0);
        send(19'(30), 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_data", int'(out_data), 0);
        chk("mid_rst_count", int'(out_count), 0);
        chk("mid_rst_ovf", int'(out_ovf), 0);
        @(negedge clk);
        rst = 1'b0;
        send(19'(7), 1'b0, 1'b0);
        send(19'(-3), 1'b0, 1'b1);
        chk_result("post_rst", 4, 2, 0);
        take();

        // Narrow accumulator: two maximum terms overflow a 19-bit sum.
`ifdef FXP_ACC_SAT_EN
        exp_b = 262143;
`else
        exp_b = -2;
`endif
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("b_in_ready", int'(b_in_ready), 1);
            b_in_valid = 1'b1; b_in_data = 19'(262143);
            @(posedge clk);
            #1;
            b_in_valid = 1'b0;
        end
        chk("b_valid", int'(b_out_valid), 1);
        chk("b_ovf", int'(b_out_ovf), 1);
        chk("b_data", int'($signed(b_out_data)), exp_b);
        chk("b_count", int'(b_out_count), 2);
        @(negedge clk);
        b_out_ready = 1'b1;

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
